// File: rtl/cmdq_ximm_issue.sv
// Command/immediate pairing issue stage: two circular FIFOs feed a single issue
// slot that only presents a flagged command once its immediate is available.
module cmdq_ximm_issue #(
  parameter int CMD_W  = 8,
  parameter int XIMM_W = 32,
  parameter int DEPTH  = 4,
  parameter int TMO    = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    io_enq_cmdq_valid,
  input  logic [CMD_W-1:0]        io_enq_cmdq_bits,
  output logic                    io_enq_cmdq_ready,
  input  logic                    io_enq_ximm1q_valid,
  input  logic [XIMM_W-1:0]       io_enq_ximm1q_bits,
  output logic                    io_enq_ximm1q_ready,
  output logic                    io_deq_valid,
  input  logic                    io_deq_ready,
  output logic [CMD_W-1:0]        io_deq_cmd,
  output logic [XIMM_W-1:0]       io_deq_imm,
  output logic                    io_deq_has_imm,
  output logic [$clog2(DEPTH):0]  io_cmdq_count,
  output logic [$clog2(DEPTH):0]  io_ximm1q_count,
  output logic                    io_imm_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (TMO > 1) ? $clog2(TMO + 1) : 1;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [SW-1:0] TMO_V = SW'(TMO);

  typedef enum logic [1:0] {IDLE, READY, WAIT_IMM} state_e;

  logic [CMD_W-1:0]  cmd_mem_q [DEPTH];
  logic [XIMM_W-1:0] imm_mem_q [DEPTH];

  logic [AW-1:0] cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
  logic [AW-1:0] imm_wr_q, imm_wr_d, imm_rd_q, imm_rd_d;
  logic [CW-1:0] cmd_cnt_q, cmd_cnt_d, imm_cnt_q, imm_cnt_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          timeout_q, timeout_d;

  state_e state;
  logic   cmd_push, cmd_pop, imm_push, imm_pop, head_flag, fire;

  // Readies depend only on registered counts, so a pop never frees a slot
  // within the same cycle.
  assign io_enq_cmdq_ready   = (cmd_cnt_q != FULL);
  assign io_enq_ximm1q_ready = (imm_cnt_q != FULL);

  assign cmd_push  = io_enq_cmdq_valid & io_enq_cmdq_ready;
  assign imm_push  = io_enq_ximm1q_valid & io_enq_ximm1q_ready;
  assign head_flag = cmd_mem_q[cmd_rd_q][CMD_W-1];

  always_comb begin
    state = IDLE;
    if (cmd_cnt_q == '0)                         state = IDLE;
    else if (!head_flag || (imm_cnt_q != '0))    state = READY;
    else                                         state = WAIT_IMM;
  end

  assign io_deq_valid   = (state == READY);
  assign fire           = io_deq_valid & io_deq_ready;
  assign cmd_pop        = fire;
  assign imm_pop        = fire & head_flag;
  assign io_deq_has_imm = io_deq_valid & head_flag;
  assign io_deq_cmd     = io_deq_valid ? cmd_mem_q[cmd_rd_q] : '0;
  assign io_deq_imm     = io_deq_has_imm ? imm_mem_q[imm_rd_q] : '0;

  assign io_cmdq_count   = cmd_cnt_q;
  assign io_ximm1q_count = imm_cnt_q;
  assign io_imm_timeout  = timeout_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cmd_wr_d  = cmd_wr_q;
    cmd_rd_d  = cmd_rd_q;
    cmd_cnt_d = cmd_cnt_q;
    imm_wr_d  = imm_wr_q;
    imm_rd_d  = imm_rd_q;
    imm_cnt_d = imm_cnt_q;

    if (cmd_push) cmd_wr_d = cmd_wr_q + AW'(1);
    if (cmd_pop)  cmd_rd_d = cmd_rd_q + AW'(1);
    if (imm_push) imm_wr_d = imm_wr_q + AW'(1);
    if (imm_pop)  imm_rd_d = imm_rd_q + AW'(1);

    case ({cmd_push, cmd_pop})
      2'b10:   cmd_cnt_d = cmd_cnt_q + CW'(1);
      2'b01:   cmd_cnt_d = cmd_cnt_q - CW'(1);
      default: cmd_cnt_d = cmd_cnt_q;
    endcase

    case ({imm_push, imm_pop})
      2'b10:   imm_cnt_d = imm_cnt_q + CW'(1);
      2'b01:   imm_cnt_d = imm_cnt_q - CW'(1);
      default: imm_cnt_d = imm_cnt_q;
    endcase
  end

  always_comb begin
    stall_d = '0;
    if (state == WAIT_IMM)
      stall_d = (stall_q == TMO_V) ? stall_q : stall_q + SW'(1);
    timeout_d = timeout_q | (stall_q == TMO_V);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_wr_q  <= '0;
      cmd_rd_q  <= '0;
      cmd_cnt_q <= '0;
      imm_wr_q  <= '0;
      imm_rd_q  <= '0;
      imm_cnt_q <= '0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      cmd_wr_q  <= cmd_wr_d;
      cmd_rd_q  <= cmd_rd_d;
      cmd_cnt_q <= cmd_cnt_d;
      imm_wr_q  <= imm_wr_d;
      imm_rd_q  <= imm_rd_d;
      imm_cnt_q <= imm_cnt_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  // NOTE: storage arrays are not reset; the counts gate every read, so stale
  // contents are never observable and the arrays can map to plain RAM.
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem_q[cmd_wr_q] <= io_enq_cmdq_bits;
    if (imm_push) imm_mem_q[imm_wr_q] <= io_enq_ximm1q_bits;
  end

endmodule

// File: tb/tb_cmdq_ximm_issue.sv
// Directed bench for cmdq_ximm_issue: one task per scenario, inline comparisons.
module tb_cmdq_ximm_issue;

  logic        clk;
  logic        reset;
  logic        io_enq_cmdq_valid;
  logic [7:0]  io_enq_cmdq_bits;
  logic        io_enq_cmdq_ready;
  logic        io_enq_ximm1q_valid;
  logic [31:0] io_enq_ximm1q_bits;
  logic        io_enq_ximm1q_ready;
  logic        io_deq_valid;
  logic        io_deq_ready;
  logic [7:0]  io_deq_cmd;
  logic [31:0] io_deq_imm;
  logic        io_deq_has_imm;
  logic [2:0]  io_cmdq_count;
  logic [2:0]  io_ximm1q_count;
  logic        io_imm_timeout;

  int total = 0;
  int bad   = 0;

  cmdq_ximm_issue #(.CMD_W(8), .XIMM_W(32), .DEPTH(4), .TMO(15)) dut (
    .clk                 (clk),
    .reset               (reset),
    .io_enq_cmdq_valid   (io_enq_cmdq_valid),
    .io_enq_cmdq_bits    (io_enq_cmdq_bits),
    .io_enq_cmdq_ready   (io_enq_cmdq_ready),
    .io_enq_ximm1q_valid (io_enq_ximm1q_valid),
    .io_enq_ximm1q_bits  (io_enq_ximm1q_bits),
    .io_enq_ximm1q_ready (io_enq_ximm1q_ready),
    .io_deq_valid        (io_deq_valid),
    .io_deq_ready        (io_deq_ready),
    .io_deq_cmd          (io_deq_cmd),
    .io_deq_imm          (io_deq_imm),
    .io_deq_has_imm      (io_deq_has_imm),
    .io_cmdq_count       (io_cmdq_count),
    .io_ximm1q_count     (io_ximm1q_count),
    .io_imm_timeout      (io_imm_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [7:0] c);
    io_enq_cmdq_valid = 1'b1;
    io_enq_cmdq_bits  = c;
    tick();
    io_enq_cmdq_valid = 1'b0;
  endtask

  task automatic push_imm(input logic [31:0] v);
    io_enq_ximm1q_valid = 1'b1;
    io_enq_ximm1q_bits  = v;
    tick();
    io_enq_ximm1q_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    io_enq_cmdq_valid = 1'b0;  io_enq_cmdq_bits   = '0;
    io_enq_ximm1q_valid = 1'b0; io_enq_ximm1q_bits = '0;
    io_deq_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    total++; if (io_deq_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h exp=0", io_deq_valid); end
    total++; if (io_enq_cmdq_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%0h exp=1", io_enq_cmdq_ready); end
    total++; if (io_enq_ximm1q_ready !== 1'b1) begin bad++; $display("FAIL rst_imm_ready got=%0h exp=1", io_enq_ximm1q_ready); end
    total++; if (io_deq_cmd !== 8'h00) begin bad++; $display("FAIL rst_cmd got=%0h exp=0", io_deq_cmd); end
    total++; if (io_deq_imm !== 32'h0) begin bad++; $display("FAIL rst_imm got=%0h exp=0", io_deq_imm); end
    total++; if (io_deq_has_imm !== 1'b0) begin bad++; $display("FAIL rst_has_imm got=%0h exp=0", io_deq_has_imm); end
    total++; if (io_cmdq_count !== 3'd0) begin bad++; $display("FAIL rst_cmd_cnt got=%0d exp=0", io_cmdq_count); end
    total++; if (io_ximm1q_count !== 3'd0) begin bad++; $display("FAIL rst_imm_cnt got=%0d exp=0", io_ximm1q_count); end
    total++; if (io_imm_timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%0h exp=0", io_imm_timeout); end
    reset = 1'b1;
  endtask

  // Called right after reset release: the very first edge must accept the push.
  task automatic test_plain_cmd();
    push_cmd(8'h05);
    total++; if (io_deq_valid !== 1'b1) begin bad++; $display("FAIL plain_valid got=%0h exp=1", io_deq_valid); end
    total++; if (io_deq_cmd !== 8'h05) begin bad++; $display("FAIL plain_cmd got=%0h exp=05", io_deq_cmd); end
    total++; if (io_deq_imm !== 32'h0) begin bad++; $display("FAIL plain_imm got=%0h exp=0", io_deq_imm); end
    total++; if (io_deq_has_imm !== 1'b0) begin bad++; $display("FAIL plain_has_imm got=%0h exp=0", io_deq_has_imm); end
    total++; if (io_cmdq_count !== 3'd1) begin bad++; $display("FAIL plain_cnt1 got=%0d exp=1", io_cmdq_count); end
    io_deq_ready = 1'b1;
    tick();
    io_deq_ready = 1'b0;
    total++; if (io_cmdq_count !== 3'd0) begin bad++; $display("FAIL plain_cnt0 got=%0d exp=0", io_cmdq_count); end
    total++; if (io_ximm1q_count !== 3'd0) begin bad++; $display("FAIL plain_icnt got=%0d exp=0", io_ximm1q_count); end
    total++; if (io_deq_valid !== 1'b0) begin bad++; $display("FAIL plain_valid0 got=%0h exp=0", io_deq_valid); end
  endtask

  task automatic test_imm_pairing();
    push_cmd(8'h85);
    total++; if (io_deq_valid !== 1'b0) begin bad++; $display("FAIL pair_wait_valid got=%0h exp=0", io_deq_valid); end
    total++; if (io_cmdq_count !== 3'd1) begin bad++; $display("FAIL pair_cnt got=%0d exp=1", io_cmdq_count); end
    io_deq_ready = 1'b1;
    tick(); tick(); tick();
    total++; if (io_cmdq_count !== 3'd1) begin bad++; $display("FAIL pair_no_pop got=%0d exp=1", io_cmdq_count); end
    push_imm(32'hDEADBEEF);
    total++; if (io_deq_valid !== 1'b1) begin bad++; $display("FAIL pair_valid got=%0h exp=1", io_deq_valid); end
    total++; if (io_deq_imm !== 32'hDEADBEEF) begin bad++; $display("FAIL pair_imm got=%0h exp=deadbeef", io_deq_imm); end
    total++; if (io_deq_cmd !== 8'h85) begin bad++; $display("FAIL pair_cmd got=%0h exp=85", io_deq_cmd); end
    total++; if (io_deq_has_imm !== 1'b1) begin bad++; $display("FAIL pair_has_imm got=%0h exp=1", io_deq_has_imm); end
    tick();
    io_deq_ready = 1'b0;
    total++; if (io_cmdq_count !== 3'd0) begin bad++; $display("FAIL pair_cnt0 got=%0d exp=0", io_cmdq_count); end
    total++; if (io_ximm1q_count !== 3'd0) begin bad++; $display("FAIL pair_icnt0 got=%0d exp=0", io_ximm1q_count); end
    total++; if (io_imm_timeout !== 1'b0) begin bad++; $display("FAIL pair_timeout got=%0h exp=0", io_imm_timeout); end
  endtask

  task automatic test_full();
    io_enq_cmdq_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      io_enq_cmdq_bits = 8'h11 + 8'(i);
      tick();
    end
    total++; if (io_cmdq_count !== 3'd4) begin bad++; $display("FAIL full_cnt got=%0d exp=4", io_cmdq_count); end
    total++; if (io_enq_cmdq_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0h exp=0", io_enq_cmdq_ready); end
    io_enq_cmdq_bits = 8'h15;
    tick();
    total++; if (io_cmdq_count !== 3'd4) begin bad++; $display("FAIL full_ignored_cnt got=%0d exp=4", io_cmdq_count); end
    total++; if (io_deq_cmd !== 8'h11) begin bad++; $display("FAIL full_head got=%0h exp=11", io_deq_cmd); end
    io_enq_cmdq_bits = 8'h16;
    io_deq_ready = 1'b1;
    #1;
    total++; if (io_enq_cmdq_ready !== 1'b0) begin bad++; $display("FAIL full_pop_ready got=%0h exp=0", io_enq_cmdq_ready); end
    total++; if (io_cmdq_count !== 3'd4) begin bad++; $display("FAIL full_pop_cnt got=%0d exp=4", io_cmdq_count); end
    tick();
    io_enq_cmdq_valid = 1'b0;
    // The push offered while full was dropped, so only the pop counts.
    total++; if (io_cmdq_count !== 3'd3) begin bad++; $display("FAIL full_after_cnt got=%0d exp=3", io_cmdq_count); end
    total++; if (io_enq_cmdq_ready !== 1'b1) begin bad++; $display("FAIL full_after_ready got=%0h exp=1", io_enq_cmdq_ready); end
    for (int j = 0; j < 3; j++) begin
      total++; if (io_deq_cmd !== 8'h12 + 8'(j)) begin bad++; $display("FAIL b2b_cmd%0d got=%0h exp=%0h", j, io_deq_cmd, 8'h12 + 8'(j)); end
      tick();
    end
    io_deq_ready = 1'b0;
    total++; if (io_cmdq_count !== 3'd0) begin bad++; $display("FAIL b2b_cnt got=%0d exp=0", io_cmdq_count); end
    total++; if (io_deq_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid got=%0h exp=0", io_deq_valid); end
  endtask

  task automatic test_timeout();
    push_cmd(8'h80);
    for (int i = 0; i < 15; i++) tick();
    total++; if (io_imm_timeout !== 1'b0) begin bad++; $display("FAIL tmo_early got=%0h exp=0", io_imm_timeout); end
    tick();
    total++; if (io_imm_timeout !== 1'b1) begin bad++; $display("FAIL tmo_set got=%0h exp=1", io_imm_timeout); end
    push_imm(32'h12345678);
    total++; if (io_deq_imm !== 32'h12345678) begin bad++; $display("FAIL tmo_imm got=%0h exp=12345678", io_deq_imm); end
    io_deq_ready = 1'b1;
    tick();
    io_deq_ready = 1'b0;
    tick();
    total++; if (io_imm_timeout !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%0h exp=1", io_imm_timeout); end
    total++; if (io_cmdq_count !== 3'd0) begin bad++; $display("FAIL tmo_cnt got=%0d exp=0", io_cmdq_count); end
  endtask

  // Interleaved stream checked against a small occupancy/order model.
  task automatic test_back_to_back();
    logic [7:0]  cmds [10];
    logic [31:0] imms [5];
    logic [15:0] rdy_pat;
    int ci, ii, oi, io_idx, cc, xc, cyc;
    logic mv, pc, px, fr, flag;
    cmds = '{8'h81, 8'h02, 8'h83, 8'h84, 8'h05, 8'h86, 8'h07, 8'h08, 8'h89, 8'h0A};
    imms = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004, 32'hA0000005};
    rdy_pat = 16'b1011_0011_1101_0110;
    ci = 0; ii = 0; oi = 0; io_idx = 0; cc = 0; xc = 0; cyc = 0;
    while (oi < 10 && cyc < 300) begin
      flag = (cc > 0) ? cmds[oi][7] : 1'b0;
      mv = (cc > 0) && (!flag || xc > 0);
      total++; if (io_deq_valid !== mv) begin bad++; $display("FAIL strm_valid cyc=%0d got=%0h exp=%0h", cyc, io_deq_valid, mv); end
      total++; if (io_cmdq_count !== 3'(cc)) begin bad++; $display("FAIL strm_ccnt cyc=%0d got=%0d exp=%0d", cyc, io_cmdq_count, cc); end
      total++; if (io_ximm1q_count !== 3'(xc)) begin bad++; $display("FAIL strm_xcnt cyc=%0d got=%0d exp=%0d", cyc, io_ximm1q_count, xc); end
      total++; if (io_enq_cmdq_ready !== (cc != 4)) begin bad++; $display("FAIL strm_cready cyc=%0d got=%0h", cyc, io_enq_cmdq_ready); end
      if (mv) begin
        total++; if (io_deq_cmd !== cmds[oi]) begin bad++; $display("FAIL strm_cmd%0d got=%0h exp=%0h", oi, io_deq_cmd, cmds[oi]); end
        total++; if (io_deq_has_imm !== flag) begin bad++; $display("FAIL strm_has%0d got=%0h exp=%0h", oi, io_deq_has_imm, flag); end
        total++; if (io_deq_imm !== (flag ? imms[io_idx] : 32'h0)) begin bad++; $display("FAIL strm_imm%0d got=%0h", oi, io_deq_imm); end
      end
      io_enq_cmdq_valid   = (ci < 10);
      io_enq_cmdq_bits    = (ci < 10) ? cmds[ci] : 8'h00;
      io_enq_ximm1q_valid = (ii < 5) && (cyc % 3 != 1);
      io_enq_ximm1q_bits  = (ii < 5) ? imms[ii] : 32'h0;
      io_deq_ready        = rdy_pat[cyc % 16];
      pc = (ci < 10) && (cc != 4);
      px = io_enq_ximm1q_valid && (xc != 4);
      fr = mv && io_deq_ready;
      cc = cc + int'(pc) - int'(fr);
      xc = xc + int'(px) - int'(fr && flag);
      ci = ci + int'(pc);
      ii = ii + int'(px);
      if (fr) begin
        oi++;
        if (flag) io_idx++;
      end
      tick();
      cyc++;
    end
    io_enq_cmdq_valid = 1'b0;
    io_enq_ximm1q_valid = 1'b0;
    io_deq_ready = 1'b0;
    total++; if (oi != 10) begin bad++; $display("FAIL strm_done got=%0d exp=10", oi); end
    total++; if (io_cmdq_count !== 3'd0) begin bad++; $display("FAIL strm_end_cnt got=%0d exp=0", io_cmdq_count); end
  endtask

  task automatic test_reset_mid();
    push_cmd(8'h81);
    push_cmd(8'h01);
    push_cmd(8'h02);
    tick(); tick(); tick();
    total++; if (io_cmdq_count !== 3'd3) begin bad++; $display("FAIL rmid_pre_cnt got=%0d exp=3", io_cmdq_count); end
    total++; if (io_deq_valid !== 1'b0) begin bad++; $display("FAIL rmid_pre_valid got=%0h exp=0", io_deq_valid); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (io_cmdq_count !== 3'd0) begin bad++; $display("FAIL rmid_cnt got=%0d exp=0", io_cmdq_count); end
    total++; if (io_deq_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0h exp=0", io_deq_valid); end
    total++; if (io_imm_timeout !== 1'b0) begin bad++; $display("FAIL rmid_timeout got=%0h exp=0", io_imm_timeout); end
    total++; if (io_enq_cmdq_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%0h exp=1", io_enq_cmdq_ready); end
    tick();
    reset = 1'b1;
    tick();
    total++; if (io_cmdq_count !== 3'd0) begin bad++; $display("FAIL rmid_post_cnt got=%0d exp=0", io_cmdq_count); end
    total++; if (io_deq_valid !== 1'b0) begin bad++; $display("FAIL rmid_post_valid got=%0h exp=0", io_deq_valid); end
  endtask

  initial begin
    test_reset();
    test_plain_cmd();
    test_imm_pairing();
    test_full();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
